// File: rtl/qcldpc_pkg.sv
// Shared types, default widths and helpers for the QC-LDPC encoder control path.
package qcldpc_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, EMIT} seq_state_t;

  localparam int unsigned NUM_Z_DEF    = 3;
  localparam int unsigned NUM_INFO_DEF = 20;
  localparam int unsigned NUM_PAR_DEF  = 4;

  localparam int unsigned ZIDX_W = $clog2(NUM_Z_DEF);
  localparam int unsigned COL_W  = $clog2(NUM_INFO_DEF);
  localparam int unsigned ADDR_W = $clog2(NUM_Z_DEF * NUM_INFO_DEF);
  localparam int unsigned PSEL_W = $clog2(NUM_PAR_DEF);

  localparam int unsigned Z_VALUES [NUM_Z_DEF] = '{27, 54, 81};

  // Highest set bit wins; callers qualify the result with a one-hot check.
  function automatic int unsigned onehot_to_idx(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/qcldpc_onehot_enc.sv
// One-hot legality check and binary index encode for a lifting-size select.
module qcldpc_onehot_enc
  import qcldpc_pkg::*;
#(
  parameter int unsigned N = NUM_Z_DEF,
  parameter int unsigned W = ZIDX_W
) (
  input  logic [N-1:0] req,
  output logic         onehot,
  output logic [W-1:0] idx
);

  assign onehot = $onehot(req);
  assign idx    = W'(onehot_to_idx(32'(req)));

endmodule

// File: rtl/qcldpc_encode_sequencer.sv
// Codeword sequencer: info-block intake, pipeline drain, parity-block emission,
// with ROM addressing and accumulator strobes for the rotate/accumulate lanes.
module qcldpc_encode_sequencer
  import qcldpc_pkg::*;
#(
  parameter int unsigned NUM_Z         = NUM_Z_DEF,
  parameter int unsigned NUM_INFO_BLKS = NUM_INFO_DEF,
  parameter int unsigned NUM_PAR_BLKS  = NUM_PAR_DEF,
  parameter int unsigned PIPE_LAT      = 2
) (
  input  logic                                   CLK,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [NUM_Z-1:0]                       req_z,
  output logic                                   busy,
  output logic                                   cfg_err,
  output logic [$clog2(NUM_Z)-1:0]               z_idx,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [$clog2(NUM_INFO_BLKS)-1:0]       col_idx,
  output logic [$clog2(NUM_Z*NUM_INFO_BLKS)-1:0] rom_addr,
  output logic                                   dp_acc_en,
  output logic                                   dp_acc_clr,
  output logic                                   par_valid,
  input  logic                                   par_ready,
  output logic [$clog2(NUM_PAR_BLKS)-1:0]        par_sel,
  output logic                                   par_last,
  output logic                                   done
);

  localparam int unsigned ZW = $clog2(NUM_Z);
  localparam int unsigned CW = $clog2(NUM_INFO_BLKS);
  localparam int unsigned AW = $clog2(NUM_Z * NUM_INFO_BLKS);
  localparam int unsigned PW = $clog2(NUM_PAR_BLKS);
  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [CW-1:0] LAST_COL = CW'(NUM_INFO_BLKS - 1);
  localparam logic [PW-1:0] LAST_PAR = PW'(NUM_PAR_BLKS - 1);

  seq_state_t    state;
  logic [DW-1:0] drain_cnt;
  logic          cfg_ok;
  logic [ZW-1:0] req_idx;

  qcldpc_onehot_enc #(.N(NUM_Z), .W(ZW)) u_enc (
    .req    (req_z),
    .onehot (cfg_ok),
    .idx    (req_idx)
  );

  assign busy       = (state != IDLE);
  assign in_ready   = (state == LOAD);
  assign par_valid  = (state == EMIT);
  assign par_last   = par_valid && (par_sel == LAST_PAR);
  assign dp_acc_en  = in_valid && in_ready;
  assign dp_acc_clr = dp_acc_en && (col_idx == '0);
  assign rom_addr   = AW'(z_idx * NUM_INFO_BLKS + col_idx);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      z_idx     <= '0;
      col_idx   <= '0;
      par_sel   <= '0;
      drain_cnt <= '0;
      cfg_err   <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state   <= LOAD;
              z_idx   <= req_idx;
              col_idx <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            col_idx <= col_idx + CW'(1);
            if (col_idx == LAST_COL) begin
              // A zero-latency datapath is already stable, so skip DRAIN entirely.
              if (PIPE_LAT == 0) begin
                state <= EMIT;
              end else begin
                state     <= DRAIN;
                drain_cnt <= DW'(PIPE_LAT - 1);
              end
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= EMIT;
          else drain_cnt <= drain_cnt - DW'(1);
        end
        EMIT: begin
          if (par_ready) begin
            if (par_sel == LAST_PAR) begin
              state   <= IDLE;
              par_sel <= '0;
              done    <= 1'b1;
            end else begin
              par_sel <= par_sel + PW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qcldpc_encode_sequencer.sv
// Scoreboard bench: stimulus queues expected ROM addresses, parity selects and
// done/cfg_err events per codeword; a monitor thread pops them as the DUT emits.
module tb_qcldpc_encode_sequencer;
  import qcldpc_pkg::*;

  localparam int NZ  = 3;
  localparam int NIB = 20;
  localparam int NPB = 4;
  localparam int LAT = 2;

  typedef struct {
    int addr;
    int clr;
    int k;
    int z;
  } acc_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NZ-1:0]     req_z = '0;
  logic              in_valid = 1'b0;
  logic              par_ready = 1'b0;
  logic              busy, cfg_err, in_ready, dp_acc_en, dp_acc_clr;
  logic              par_valid, par_last, done;
  logic [ZIDX_W-1:0] z_idx;
  logic [COL_W-1:0]  col_idx;
  logic [ADDR_W-1:0] rom_addr;
  logic [PSEL_W-1:0] par_sel;

  logic              z_start = 1'b0;
  logic [NZ-1:0]     z_req = '0;
  logic              z_in_valid = 1'b0;
  logic              z_par_ready = 1'b0;
  logic              z_busy, z_cfg_err, z_in_ready, z_acc_en, z_acc_clr;
  logic              z_par_valid, z_par_last, z_done;
  logic [ZIDX_W-1:0] z_zidx;
  logic [COL_W-1:0]  z_col;
  logic [ADDR_W-1:0] z_rom;
  logic [PSEL_W-1:0] z_psel;

  acc_t exp_acc[$];
  int   exp_par[$];
  int   exp_done = 0;
  int   exp_cfg = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_hs = -100;
  bit   pv_prev = 1'b0;

  always #5 clk = ~clk;

  qcldpc_encode_sequencer #(
    .NUM_Z(NZ), .NUM_INFO_BLKS(NIB), .NUM_PAR_BLKS(NPB), .PIPE_LAT(LAT)
  ) dut (
    .CLK(clk), .rst_n(rst_n), .start(start), .req_z(req_z), .busy(busy),
    .cfg_err(cfg_err), .z_idx(z_idx), .in_valid(in_valid), .in_ready(in_ready),
    .col_idx(col_idx), .rom_addr(rom_addr), .dp_acc_en(dp_acc_en),
    .dp_acc_clr(dp_acc_clr), .par_valid(par_valid), .par_ready(par_ready),
    .par_sel(par_sel), .par_last(par_last), .done(done)
  );

  qcldpc_encode_sequencer #(
    .NUM_Z(NZ), .NUM_INFO_BLKS(NIB), .NUM_PAR_BLKS(NPB), .PIPE_LAT(0)
  ) dut0 (
    .CLK(clk), .rst_n(rst_n), .start(z_start), .req_z(z_req), .busy(z_busy),
    .cfg_err(z_cfg_err), .z_idx(z_zidx), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .col_idx(z_col), .rom_addr(z_rom), .dp_acc_en(z_acc_en),
    .dp_acc_clr(z_acc_clr), .par_valid(z_par_valid), .par_ready(z_par_ready),
    .par_sel(z_psel), .par_last(z_par_last), .done(z_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_cfg_err"},   int'(cfg_err), 0);
    chk({tag, "_in_ready"},  int'(in_ready), 0);
    chk({tag, "_acc_en"},    int'(dp_acc_en), 0);
    chk({tag, "_acc_clr"},   int'(dp_acc_clr), 0);
    chk({tag, "_par_valid"}, int'(par_valid), 0);
    chk({tag, "_par_last"},  int'(par_last), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_z_idx"},     int'(z_idx), 0);
    chk({tag, "_col_idx"},   int'(col_idx), 0);
    chk({tag, "_par_sel"},   int'(par_sel), 0);
    chk({tag, "_rom_addr"},  int'(rom_addr), 0);
  endtask

  task automatic flush_model();
    exp_acc.delete();
    exp_par.delete();
    exp_done = 0;
  endtask

  // mode: 0 both sides ready, 1 in_valid toggles, 2 random, 3 par_ready held low 5 cycles at par_sel=1
  task automatic run_cw(input int z, input int mode, input int abort_col, input int exp_total);
    logic [NZ-1:0] oh;
    int  n;
    int  hold;
    bit  fin;
    oh = '0;
    oh[z] = 1'b1;
    @(negedge clk);
    start = 1'b1;
    req_z = oh;
    in_valid = 1'b1;
    par_ready = 1'b1;
    for (int k = 0; k < NIB; k++) exp_acc.push_back('{z * NIB + k, int'(k == 0), k, z});
    for (int p = 0; p < NPB; p++) exp_par.push_back(p);
    exp_done++;
    @(posedge clk); #1;
    start = 1'b0;
    req_z = NZ'($urandom);
    chk("start_to_ready", int'(in_ready), 1);
    chk("start_busy", int'(busy), 1);
    n = 1;
    hold = 0;
    fin = 1'b0;
    while (!fin && n < 400) begin
      if (abort_col >= 0 && int'(col_idx) == abort_col && in_ready) begin
        #2 rst_n = 1'b0;
        #1 chk_idle("rst_async");
        flush_model();
        @(negedge clk);
        chk_idle("rst_hold");
        rst_n = 1'b1;
        in_valid = 1'b0;
        par_ready = 1'b1;
        start = 1'b0;
        return;
      end
      case (mode)
        1: in_valid = ~in_valid;
        2: begin
          in_valid  = ($urandom_range(0, 3) != 0);
          par_ready = ($urandom_range(0, 2) != 0);
          start     = busy ? 1'($urandom) : 1'b0;
          req_z     = NZ'($urandom);
        end
        3: begin
          if (hold > 0 && hold < 5) begin
            chk("bp_sel_held", int'(par_sel), 1);
            chk("bp_valid_held", int'(par_valid), 1);
            par_ready = 1'b0;
            hold++;
          end else if (hold == 0 && par_valid && par_sel == 1) begin
            par_ready = 1'b0;
            hold = 1;
          end else begin
            par_ready = 1'b1;
          end
        end
        default: ;
      endcase
      @(posedge clk); #1;
      n++;
      if (done) fin = 1'b1;
    end
    start = 1'b0;
    in_valid = 1'b0;
    par_ready = 1'b1;
    if (!fin) begin
      chk("done_timeout", int'(done), 1);
      flush_model();
    end else if (exp_total > 0) begin
      chk("codeword_cycles", n, exp_total);
    end
    if (mode == 3) chk("bp_low_cycles", hold, 5);
  endtask

  task automatic cfg_bad(input logic [NZ-1:0] r);
    @(negedge clk);
    start = 1'b1;
    req_z = r;
    in_valid = 1'b1;
    exp_cfg++;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_err_pulse", int'(cfg_err), 1);
    chk("cfg_busy", int'(busy), 0);
    chk("cfg_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("cfg_err_clear", int'(cfg_err), 0);
    chk("cfg_busy_after", int'(busy), 0);
    chk("cfg_in_ready_after", int'(in_ready), 0);
    in_valid = 1'b0;
  endtask

  task automatic run_lat0();
    int n;
    @(negedge clk);
    z_req = 3'b010;
    z_start = 1'b1;
    z_in_valid = 1'b1;
    z_par_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        chk("lat0_first_addr", int'(z_rom), NIB);
        chk("lat0_first_clr", int'(z_acc_clr), 1);
      end
      if (n == 20) begin
        chk("lat0_last_load_ready", int'(z_in_ready), 1);
        chk("lat0_last_load_pv", int'(z_par_valid), 0);
      end
      if (n == 21) begin
        chk("lat0_emit_pv", int'(z_par_valid), 1);
        chk("lat0_emit_sel", int'(z_psel), 0);
      end
    end while (!z_done && n < 200);
    chk("lat0_cycles", n, 1 + NIB + NPB);
    @(posedge clk); #1;
    chk("b2b_relaunch_busy", int'(z_busy), 1);
    chk("b2b_relaunch_ready", int'(z_in_ready), 1);
    chk("b2b_relaunch_col", int'(z_col), 0);
    z_start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!z_done && n < 200);
    chk("b2b_second_cycles", n, NIB + NPB);
    z_in_valid = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          pv_prev = 1'b0;
        end else begin
          cyc++;
          if (dp_acc_en) begin
            if (exp_acc.size() == 0) begin
              chk("acc_unexpected", int'(dp_acc_en), 0);
            end else begin
              acc_t e;
              e = exp_acc.pop_front();
              chk("rom_addr", int'(rom_addr), e.addr);
              chk("acc_clr", int'(dp_acc_clr), e.clr);
              chk("col_idx", int'(col_idx), e.k);
              chk("z_idx", int'(z_idx), e.z);
              if (e.k == NIB - 1) last_hs = cyc;
            end
          end
          if (par_valid && !pv_prev) chk("drain_latency", cyc - last_hs, LAT + 1);
          pv_prev = par_valid;
          if (par_valid && par_ready) begin
            if (exp_par.size() == 0) begin
              chk("par_unexpected", int'(par_valid), 0);
            end else begin
              int p;
              p = exp_par.pop_front();
              chk("par_sel", int'(par_sel), p);
              chk("par_last", int'(par_last), int'(p == NPB - 1));
            end
          end
          if (done) begin
            chk("done_expected", int'(exp_done > 0), 1);
            chk("done_after_last_par", exp_par.size(), 0);
            chk("done_all_cols", exp_acc.size(), 0);
            if (exp_done > 0) exp_done--;
          end
          if (cfg_err) begin
            chk("cfg_err_expected", int'(exp_cfg > 0), 1);
            if (exp_cfg > 0) exp_cfg--;
          end
        end
      end
      begin
        #12;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_cw(1, 0, -1, 1 + NIB + LAT + NPB);
        cfg_bad(3'b011);
        cfg_bad(3'b000);
        run_cw(2, 1, -1, 0);
        run_cw(0, 3, -1, 0);
        run_cw(1, 0, 7, 0);
        run_cw(1, 0, -1, 1 + NIB + LAT + NPB);
        for (int i = 0; i < 8; i++) begin
          run_cw(int'($urandom_range(0, NZ - 1)), 2, -1, 0);
          if ($urandom_range(0, 2) == 0) cfg_bad(3'b101);
        end
        run_lat0();
        repeat (3) @(posedge clk);
        #1;
        chk("left_acc", exp_acc.size(), 0);
        chk("left_par", exp_par.size(), 0);
        chk("left_done", exp_done, 0);
        chk("left_cfg", exp_cfg, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    join
  end

endmodule

// File: doc/qcldpc_encode_sequencer.md
# qcldpc_encode_sequencer

Control sequencer for the row-parallel QC-LDPC encoder datapath. It latches the requested lifting size and walks one codeword through three phases: information-block intake, pipeline drain and parity-block emission. It generates the proto-matrix ROM address and the accumulator clear/enable strobes, and runs valid/ready handshakes on both the info-block input and the parity-block output. It sits between the upstream data source, the shift-value ROM and the rotate/accumulate lanes.

## Interface
Parameters:
- NUM_Z, 3: number of supported lifting sizes (27/54/81).
- NUM_INFO_BLKS, 20: info blocks (proto-matrix columns) per codeword.
- NUM_PAR_BLKS, 4: parity blocks (rows) per codeword.
- PIPE_LAT, 2: datapath cycles from accumulate strobe to a stable accumulator; 0 is legal.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin a codeword; sampled only in IDLE.
- req_z  in  NUM_Z  one-hot lifting-size select; sampled together with start.
- busy  out  1  high in every state except IDLE.
- cfg_err  out  1  one-cycle pulse when start arrives in IDLE with req_z not one-hot.
- z_idx  out  $clog2(NUM_Z)  latched lifting-size index, held until the next accepted start.
- in_valid  in  1  upstream info block valid.
- in_ready  out  1  sequencer accepts an info block.
- col_idx  out  $clog2(NUM_INFO_BLKS)  current column.
- rom_addr  out  $clog2(NUM_Z*NUM_INFO_BLKS)  shift-value ROM word address.
- dp_acc_en  out  1  datapath XOR-accumulate strobe.
- dp_acc_clr  out  1  with dp_acc_en, load the accumulators instead of XORing (first column).
- par_valid  out  1  parity block par_sel is stable.
- par_ready  in  1  downstream accepts the parity block.
- par_sel  out  $clog2(NUM_PAR_BLKS)  parity lane to read out.
- par_last  out  1  par_sel == NUM_PAR_BLKS-1 while par_valid.
- done  out  1  one-cycle pulse after the last parity handshake.

## Operation
States:
- IDLE -> LOAD: start && $onehot(req_z). Latch z_idx and clear col_idx.
- IDLE -> IDLE: start && !$onehot(req_z). Pulse cfg_err.
- LOAD -> DRAIN: on the handshake at col_idx == NUM_INFO_BLKS-1. Load drain_cnt = PIPE_LAT-1. If PIPE_LAT == 0, go directly to EMIT.
- DRAIN -> EMIT: when drain_cnt == 0. drain_cnt decrements every cycle.
- EMIT -> IDLE: on the handshake at par_last. done pulses in the first IDLE cycle.

Datapath outputs:
- in_ready = (state == LOAD).
- A handshake occurs when in_valid && in_ready. Each handshake increments col_idx; there is no wrap inside a codeword.
- rom_addr = z_idx*NUM_INFO_BLKS + col_idx. It is combinational from registered state, so the ROM word aligns with the handshake cycle.
- dp_acc_en = in_valid && in_ready.
- dp_acc_clr = dp_acc_en && col_idx == 0.

Output side:
- In EMIT, par_valid = 1.
- par_sel starts at 0, increments on each par_valid && par_ready, and returns to 0 on exit.
- If par_ready is low, par_sel holds and par_valid stays high.

Boundary behaviour:
- start or req_z outside IDLE: ignored, no cfg_err.
- in_valid outside LOAD: ignored, no strobes.
- in_valid gaps in LOAD: col_idx holds, no strobes.
- z_idx is stable from LOAD through EMIT.
- rst_n low at any time: returns to IDLE immediately. The partial codeword is discarded and no done pulse is produced.

## Timing
- Reset values: busy, cfg_err, in_ready, dp_acc_en, dp_acc_clr, par_valid, par_last and done are 0. z_idx, col_idx, par_sel and rom_addr are 0.
- Latency, start cycle to first in_ready: 1 cycle.
- Latency, last input handshake to first par_valid: PIPE_LAT+1 cycles.
- Minimum codeword time with both sides always ready: 1 + NUM_INFO_BLKS + PIPE_LAT + NUM_PAR_BLKS cycles. Back-to-back codewords add 1 IDLE cycle.
- Outputs derived from state (busy, in_ready, par_valid, par_sel, par_last) are decoded from registers only.
- dp_acc_en and dp_acc_clr are combinational from in_valid.
- cfg_err and done are registered pulses.

## Structure
- Package qcldpc_pkg holds:
  - the seq_state_t enum {IDLE, LOAD, DRAIN, EMIT};
  - width localparams for Z index, column, ROM address and parity select;
  - the Z value list {27, 54, 81};
  - a onehot_to_idx function.
- One sub-module, qcldpc_onehot_enc, performs the one-hot check plus index encode for req_z. It is shared with the ROM wrapper.
- Everything else (FSM, counters, address arithmetic) is in the top level.

## Test plan
- Nominal run: req_z=3'b010, in_valid and par_ready always 1, PIPE_LAT=2. Expect:
  - rom_addr walks 20..39, with dp_acc_clr only at rom_addr 20;
  - par_valid begins 3 cycles after the 20th handshake;
  - par_sel goes 0..3 with par_last at 3, then done;
  - total 27 cycles.
- Invalid config: req_z=3'b011 or 3'b000 with start. Expect a cfg_err pulse, busy stays 0, and in_ready never asserts.
- Input throttle: in_valid toggles 1/0. Expect exactly 20 dp_acc_en pulses, col_idx frozen during gaps, and rom_addr for z_idx=2 spanning 40..59.
- Output backpressure: par_ready low for 5 cycles at par_sel=1. Expect par_sel held at 1, par_valid steady, and done only after the par_sel=3 handshake.
- Reset mid-codeword: rst_n asserted at col_idx=7. Expect all outputs at reset values asynchronously and no done. A fresh start then runs cleanly from col_idx 0.
- PIPE_LAT=0 and back-to-back codewords: expect LOAD->EMIT with no DRAIN cycle, and a start held high relaunches one cycle after done.
